// File: rtl/i2c_req_arbiter.sv
// Two-requester round-robin front end for an I2C master: latches the winner's
// descriptor, sequences Start/Ready handshakes, and reports status with a timeout.
module i2c_req_arbiter #(
   parameter logic [15:0] TO_MAX = 16'd60000
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        Req0,
   input  logic        Req1,
   input  logic [32:0] Desc0,
   input  logic [32:0] Desc1,
   output logic        Done0,
   output logic        Done1,
   output logic        Err,
   output logic        Tout,
   output logic [7:0]  Rdata,
   output logic        Busy,
   output logic        M_Start,
   output logic [6:0]  M_Adr,
   output logic        M_R_W,
   output logic        M_Set_pointer,
   output logic [7:0]  M_Pointer,
   output logic [7:0]  M_Data_in,
   output logic [7:0]  M_Data_in2,
   input  logic        M_Ready,
   input  logic        M_Error,
   input  logic        M_Data_valid,
   input  logic [7:0]  M_Data_out
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t      state, state_n;
   logic [32:0] desc_q;
   logic        grant, grant_n, grant_en;
   logic        last;
   logic [15:0] cnt, cnt_n;
   logic        err_flag, err_flag_n;
   logic        tout_flag, tout_flag_n;
   logic [7:0]  shadow, shadow_n;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v >= TO_MAX) ? TO_MAX : v + 16'd1;
   endfunction

   always_comb begin
      state_n     = state;
      grant_n     = grant;
      grant_en    = 1'b0;
      cnt_n       = cnt;
      err_flag_n  = err_flag;
      tout_flag_n = tout_flag;
      shadow_n    = shadow;
      case (state)
         IDLE: begin
            if ((Req0 || Req1) && M_Ready) begin
               grant_en    = 1'b1;
               // Contention goes to whoever was not served last.
               grant_n     = (Req0 && Req1) ? ~last : Req1;
               cnt_n       = 16'd0;
               err_flag_n  = 1'b0;
               tout_flag_n = 1'b0;
               shadow_n    = 8'd0;
               state_n     = ISSUE;
            end
         end
         ISSUE: begin
            cnt_n = sat_inc(cnt);
            if (cnt >= TO_MAX) begin
               err_flag_n  = 1'b1;
               tout_flag_n = 1'b1;
               state_n     = DONE;
            end else if (!M_Ready) begin
               state_n = WAIT;
            end
         end
         WAIT: begin
            cnt_n = sat_inc(cnt);
            if (M_Data_valid) shadow_n = M_Data_out;
            if (M_Error) err_flag_n = 1'b1;
            if (cnt >= TO_MAX) begin
               err_flag_n  = 1'b1;
               tout_flag_n = 1'b1;
               state_n     = DONE;
            end else if (M_Ready) begin
               state_n = DONE;
            end
         end
         DONE: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state     <= IDLE;
         grant     <= 1'b0;
         last      <= 1'b1;
         cnt       <= 16'd0;
         err_flag  <= 1'b0;
         tout_flag <= 1'b0;
         desc_q    <= '0;
         Err       <= 1'b0;
         Tout      <= 1'b0;
         Rdata     <= 8'd0;
      end else begin
         state     <= state_n;
         grant     <= grant_n;
         cnt       <= cnt_n;
         err_flag  <= err_flag_n;
         tout_flag <= tout_flag_n;
         if (grant_en) desc_q <= grant_n ? Desc1 : Desc0;
         // Status is published on entry to DONE so it is valid alongside the pulse.
         if (state != DONE && state_n == DONE) begin
            Err   <= err_flag_n;
            Tout  <= tout_flag_n;
            Rdata <= shadow_n;
         end
         if (state == DONE) last <= grant;
      end
   end

   // Read shadow is data only; it is cleared on every grant before use.
   always_ff @(posedge Clk) begin
      shadow <= shadow_n;
   end

   assign Busy    = (state != IDLE);
   assign M_Start = (state == ISSUE);
   assign Done0   = (state == DONE) && !grant;
   assign Done1   = (state == DONE) && grant;
   assign {M_Adr, M_R_W, M_Set_pointer, M_Pointer, M_Data_in, M_Data_in2} = desc_q;

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Directed bench for i2c_req_arbiter: reset, round-robin, transaction vectors,
// timeout and mid-transaction reset, against a small negedge-driven master model.
module tb_i2c_req_arbiter;

   logic        Clk, Rst, Req0, Req1;
   logic [32:0] Desc0, Desc1;
   logic        Done0, Done1, Err, Tout, Busy, M_Start, M_R_W, M_Set_pointer;
   logic [6:0]  M_Adr;
   logic [7:0]  Rdata, M_Pointer, M_Data_in, M_Data_in2, M_Data_out;
   logic        M_Ready, M_Error, M_Data_valid;
   logic [32:0] m_desc;

   int n_tests = 0;
   int n_fail  = 0;

   int         mst_hold, mst_busy;
   logic       mst_err, mst_dv, mst_same, mst_never;
   logic [7:0] mst_dout;

   typedef struct {
      logic        req0, req1;
      logic [32:0] desc0, desc1;
      int          hold, busy;
      logic        merr, dv, same, never, drop, chg;
      logic [7:0]  dout;
      logic        exp_g, exp_err, exp_tout;
      logic [7:0]  exp_rdata;
      int          exp_starts, exp_lat;
   } vec_t;

   i2c_req_arbiter #(.TO_MAX(16'd100)) dut (
      .Clk(Clk), .Rst(Rst), .Req0(Req0), .Req1(Req1), .Desc0(Desc0), .Desc1(Desc1),
      .Done0(Done0), .Done1(Done1), .Err(Err), .Tout(Tout), .Rdata(Rdata), .Busy(Busy),
      .M_Start(M_Start), .M_Adr(M_Adr), .M_R_W(M_R_W), .M_Set_pointer(M_Set_pointer),
      .M_Pointer(M_Pointer), .M_Data_in(M_Data_in), .M_Data_in2(M_Data_in2),
      .M_Ready(M_Ready), .M_Error(M_Error), .M_Data_valid(M_Data_valid), .M_Data_out(M_Data_out)
   );

   assign m_desc = {M_Adr, M_R_W, M_Set_pointer, M_Pointer, M_Data_in, M_Data_in2};

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // Master model: holds Ready high for mst_hold+1 Start cycles, busy for mst_busy, then readies.
   initial begin : master
      int ph, hc, bc;
      ph = 0; hc = 0; bc = 0;
      M_Ready = 1'b1; M_Error = 1'b0; M_Data_valid = 1'b0; M_Data_out = 8'd0;
      forever begin
         @(negedge Clk);
         if (!Rst) begin
            ph = 0; hc = 0; bc = 0;
            M_Ready = 1'b1; M_Error = 1'b0; M_Data_valid = 1'b0;
         end else begin
            case (ph)
               0: begin
                  if (M_Start) begin
                     hc++;
                     if (!mst_never && hc == mst_hold + 1) begin
                        M_Ready = 1'b0; hc = 0; bc = 0; ph = 2;
                     end
                  end else begin
                     hc = 0;
                  end
               end
               2: begin
                  bc++;
                  if (bc == mst_busy) begin
                     M_Error = mst_err; M_Data_valid = mst_dv; M_Data_out = mst_dout;
                     if (mst_same) M_Ready = 1'b1;
                     ph = 3;
                  end
               end
               default: begin
                  M_Error = 1'b0; M_Data_valid = 1'b0; M_Ready = 1'b1; ph = 0;
               end
            endcase
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [32:0] dsc(input logic [6:0] a, input logic rw, input logic sp,
                                       input logic [7:0] p, input logic [7:0] di, input logic [7:0] di2);
      return {a, rw, sp, p, di, di2};
   endfunction

   function automatic vec_t mk(input logic r0, input logic r1, input logic [32:0] d0, input logic [32:0] d1,
                               input int hold, input int busy, input logic merr, input logic dv,
                               input logic same, input logic never, input logic drop, input logic chg,
                               input logic [7:0] dout, input logic eg, input logic ee, input logic et,
                               input logic [7:0] er, input int es, input int el);
      vec_t v;
      v.req0 = r0; v.req1 = r1; v.desc0 = d0; v.desc1 = d1; v.hold = hold; v.busy = busy;
      v.merr = merr; v.dv = dv; v.same = same; v.never = never; v.drop = drop; v.chg = chg;
      v.dout = dout; v.exp_g = eg; v.exp_err = ee; v.exp_tout = et; v.exp_rdata = er;
      v.exp_starts = es; v.exp_lat = el;
      return v;
   endfunction

   task automatic wait_done(input int bound, output bit got, output logic who);
      int n;
      got = 1'b0; who = 1'b0; n = 0;
      while (!got && n < bound) begin
         @(negedge Clk); n++;
         if (Done0 || Done1) begin got = 1'b1; who = Done1; end
      end
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int cyc, s_cyc, d_cyc, starts, busy_n;
      bit got, desc_ok, changed;
      logic who, both;
      logic [32:0] exp_desc;
      @(negedge Clk);
      mst_hold = v.hold; mst_busy = v.busy; mst_err = v.merr; mst_dv = v.dv;
      mst_same = v.same; mst_never = v.never; mst_dout = v.dout;
      Desc0 = v.desc0; Desc1 = v.desc1; Req0 = v.req0; Req1 = v.req1;
      exp_desc = v.exp_g ? v.desc1 : v.desc0;
      cyc = 0; s_cyc = -1; d_cyc = 0; starts = 0; busy_n = 0;
      got = 1'b0; desc_ok = 1'b1; changed = 1'b0; who = 1'b0; both = 1'b0;
      while (!got && cyc < 400) begin
         @(negedge Clk); cyc++;
         if (M_Start) begin
            starts++;
            if (s_cyc < 0) s_cyc = cyc;
         end
         if (Busy) begin
            busy_n++;
            if (m_desc !== exp_desc) desc_ok = 1'b0;
            if (v.drop && busy_n == 1) begin Req0 = 1'b0; Req1 = 1'b0; end
            if (v.chg && !changed && !M_Start) begin
               Desc0 = ~Desc0; Desc1 = ~Desc1; changed = 1'b1;
            end
         end
         if (Done0 || Done1) begin
            got = 1'b1; d_cyc = cyc; who = Done1; both = Done0 & Done1;
            Req0 = 1'b0; Req1 = 1'b0;
         end
      end
      if (!got) begin
         n_tests++; n_fail++;
         $display("FAIL v%0d_done: no Done pulse within 400 cycles, expected Done%0d", idx, v.exp_g);
         return;
      end
      chk($sformatf("v%0d_who", idx), 64'(who), 64'(v.exp_g));
      chk($sformatf("v%0d_both", idx), 64'(both), 64'd0);
      chk($sformatf("v%0d_err", idx), 64'(Err), 64'(v.exp_err));
      chk($sformatf("v%0d_tout", idx), 64'(Tout), 64'(v.exp_tout));
      chk($sformatf("v%0d_rdata", idx), 64'(Rdata), 64'(v.exp_rdata));
      chk($sformatf("v%0d_starts", idx), 64'(starts), 64'(v.exp_starts));
      chk($sformatf("v%0d_lat", idx), 64'(d_cyc - s_cyc), 64'(v.exp_lat));
      chk($sformatf("v%0d_desc_stable", idx), 64'(desc_ok), 64'd1);
      @(negedge Clk);
      chk($sformatf("v%0d_pulse_once", idx), 64'(Done0 | Done1), 64'd0);
      chk($sformatf("v%0d_idle", idx), 64'(Busy), 64'd0);
      chk($sformatf("v%0d_err_hold", idx), 64'(Err), 64'(v.exp_err));
      chk($sformatf("v%0d_rdata_hold", idx), 64'(Rdata), 64'(v.exp_rdata));
      chk($sformatf("v%0d_desc_hold", idx), 64'(m_desc), 64'(exp_desc));
   endtask

   initial begin : main
      vec_t vt [7];
      int   done_cyc [4];
      logic done_who [4];
      int   nd, cyc, nw;
      logic both, who, seen;
      bit   got;

      vt[0] = mk(1'b1, 1'b0, dsc(7'h48, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00), dsc(7'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00),
                 20, 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 8'hA5, 21, 23);
      vt[1] = mk(1'b0, 1'b1, dsc(7'h10, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00), dsc(7'h21, 1'b0, 1'b1, 8'h10, 8'h33, 8'h44),
                 3, 2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hEE, 1'b1, 1'b1, 1'b0, 8'h00, 4, 7);
      vt[2] = mk(1'b1, 1'b1, dsc(7'h50, 1'b1, 1'b1, 8'h02, 8'h00, 8'h00), dsc(7'h51, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00),
                 0, 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h3C, 1, 3);
      vt[3] = mk(1'b1, 1'b1, dsc(7'h60, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00), dsc(7'h1A, 1'b1, 1'b1, 8'h7F, 8'h01, 8'h02),
                 1, 3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'hC3, 1'b1, 1'b0, 1'b0, 8'hC3, 2, 6);
      vt[4] = mk(1'b1, 1'b0, dsc(7'h33, 1'b0, 1'b0, 8'h00, 8'h5A, 8'hA5), dsc(7'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00),
                 2, 1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 3, 4);
      vt[5] = mk(1'b0, 1'b1, dsc(7'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00), dsc(7'h7F, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00),
                 0, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h00, 101, 101);
      vt[6] = mk(1'b1, 1'b0, dsc(7'h44, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00), dsc(7'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00),
                 1, 1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b0, 8'h5A, 2, 4);

      // Reset state, then both requesters held high from reset.
      Rst = 1'b0; Req0 = 1'b1; Req1 = 1'b1;
      Desc0 = dsc(7'h11, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
      Desc1 = dsc(7'h22, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
      mst_hold = 1; mst_busy = 1; mst_err = 1'b0; mst_dv = 1'b1;
      mst_same = 1'b0; mst_never = 1'b0; mst_dout = 8'h11;
      @(negedge Clk);
      chk("rst_busy", 64'(Busy), 64'd0);
      chk("rst_start", 64'(M_Start), 64'd0);
      chk("rst_fields", 64'(m_desc), 64'd0);
      chk("rst_done", 64'({Done0, Done1}), 64'd0);
      chk("rst_status", 64'({Err, Tout, Rdata}), 64'd0);
      Rst = 1'b1;
      for (int k = 0; k < 4; k++) begin done_cyc[k] = 0; done_who[k] = 1'bx; end
      nd = 0; cyc = 0; both = 1'b0;
      while (nd < 4 && cyc < 200) begin
         @(negedge Clk); cyc++;
         if (Done0 && Done1) both = 1'b1;
         if (Done0 || Done1) begin done_who[nd] = Done1; done_cyc[nd] = cyc; nd++; end
      end
      Req0 = 1'b0; Req1 = 1'b0;
      chk("rr_count", 64'(nd), 64'd4);
      for (int k = 0; k < 4; k++) chk($sformatf("rr_order%0d", k), 64'(done_who[k]), 64'(k % 2));
      chk("rr_both", 64'(both), 64'd0);
      for (int k = 0; k < 3; k++) chk($sformatf("rr_gap%0d", k), 64'(done_cyc[k+1] - done_cyc[k]), 64'd6);

      for (int i = 0; i < 7; i++) run_vec(i, vt[i]);

      // Reset five cycles into WAIT abandons the transaction silently.
      @(negedge Clk);
      mst_hold = 1; mst_busy = 20; mst_err = 1'b0; mst_dv = 1'b1;
      mst_same = 1'b0; mst_never = 1'b0; mst_dout = 8'h77;
      Desc0 = dsc(7'h3C, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00); Req0 = 1'b1; Req1 = 1'b0;
      cyc = 0; nw = 0;
      while (nw < 5 && cyc < 100) begin
         @(negedge Clk); cyc++;
         if (Busy && !M_Start) nw++;
      end
      chk("arst_reach_wait", 64'(nw), 64'd5);
      Rst = 1'b0;
      #1;
      chk("arst_busy", 64'(Busy), 64'd0);
      chk("arst_start", 64'(M_Start), 64'd0);
      chk("arst_fields", 64'(m_desc), 64'd0);
      chk("arst_status", 64'({Done0, Done1, Err, Tout, Rdata}), 64'd0);
      Req0 = 1'b0;
      seen = 1'b0;
      repeat (3) begin
         @(negedge Clk);
         if (Done0 || Done1) seen = 1'b1;
      end
      chk("arst_no_done", 64'(seen), 64'd0);
      mst_hold = 0; mst_busy = 1; mst_dv = 1'b1; mst_dout = 8'h9C;
      Desc1 = dsc(7'h2B, 1'b1, 1'b1, 8'h05, 8'h00, 8'h00); Req1 = 1'b1;
      Rst = 1'b1;
      wait_done(100, got, who);
      Req1 = 1'b0;
      chk("post_rst_got", 64'(got), 64'd1);
      chk("post_rst_who", 64'(who), 64'd1);
      chk("post_rst_rdata", 64'(Rdata), 64'h9C);
      chk("post_rst_fields", 64'(m_desc), 64'(dsc(7'h2B, 1'b1, 1'b1, 8'h05, 8'h00, 8'h00)));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
